// File: rtl/demux_1_n_stream_v.sv
// 1-to-N stream demultiplexer with a single holding register.
// Unicast, broadcast and out-of-range drop with a saturating drop counter.
module demux_1_n_stream_v #(
    parameter int N = 8,
    parameter int DW = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    input  logic [SW-1:0] i_sel_code,
    input  logic          i_bcast,
    output logic [N-1:0]  o_valid,
    input  logic [N-1:0]  i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_err,
    output logic [7:0]    o_drop_cnt
);

    localparam logic [SW:0] N_L = (SW+1)'(N);

    logic [N-1:0]  mask_q, mask_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic [7:0]    drop_q, drop_d;

    logic          accept;
    logic          in_range;
    logic [N-1:0]  onehot;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            mask_q <= mask_d;
            data_q <= data_d;
            err_q  <= err_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            onehot[k] = (i_sel_code == SW'(k));
        end
    end

    // Ready when no pending channel would still be waiting after this edge.
    assign o_ready  = ~|(mask_q & ~i_ready);
    assign accept   = i_valid & o_ready;
    assign in_range = ({1'b0, i_sel_code} < N_L);

    always_comb begin
        mask_d = mask_q & ~i_ready;
        data_d = data_q;
        err_d  = 1'b0;
        drop_d = drop_q;
        if (accept) begin
            if (i_bcast) begin
                mask_d = '1;
                data_d = i_data;
            end else if (in_range) begin
                mask_d = onehot;
                data_d = i_data;
            end else begin
                mask_d = '0;
                err_d  = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    assign o_valid    = mask_q;
    assign o_data     = data_q;
    assign o_err      = err_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_demux_1_n_stream_v.sv
// Bench for demux_1_n_stream_v: N=8 instance plus N=6 instance
// for out-of-range drops, with a queue of expected words.
module tb_demux_1_n_stream_v;

    logic       clk;
    logic       rst_n;

    logic       valid;
    logic       rdy;
    logic [7:0] data;
    logic [2:0] sel;
    logic       bcast;
    logic [7:0] ov;
    logic [7:0] ready;
    logic [7:0] od;
    logic       oe;
    logic [7:0] dc;

    logic       v6;
    logic       rdy6;
    logic [7:0] d6;
    logic [2:0] sel6;
    logic       b6;
    logic [5:0] ov6;
    logic [5:0] r6;
    logic [7:0] od6;
    logic       oe6;
    logic [7:0] dc6;

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] d;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   errors;
    int   checks;

    demux_1_n_stream_v #(.N(8), .DW(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (rdy),
        .i_data     (data),
        .i_sel_code (sel),
        .i_bcast    (bcast),
        .o_valid    (ov),
        .i_ready    (ready),
        .o_data     (od),
        .o_err      (oe),
        .o_drop_cnt (dc)
    );

    demux_1_n_stream_v #(.N(6), .DW(8)) dut6 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (v6),
        .o_ready    (rdy6),
        .i_data     (d6),
        .i_sel_code (sel6),
        .i_bcast    (b6),
        .o_valid    (ov6),
        .i_ready    (r6),
        .o_data     (od6),
        .o_err      (oe6),
        .o_drop_cnt (dc6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 0; data = 0; sel = 0; bcast = 0; ready = 0;
        v6 = 0; d6 = 0; sel6 = 0; b6 = 0; r6 = '1;
        #3;
        checks++;
        if (ov !== 8'h00 || od !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: ov=%h od=%h want 00 00", ov, od);
        end
        checks++;
        if (rdy !== 1'b1 || oe !== 1'b0 || dc !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctl: rdy=%b oe=%b dc=%0d want 1 0 0",
                     rdy, oe, dc);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unicast();
        valid = 1; data = 8'hA5; sel = 3; bcast = 0; ready = 8'hFF;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL uni_ready: got %b want 1", rdy);
        end
        sbq.push_back('{m: 8'h08, d: 8'hA5});
        tick();
        valid = 0;
        e = sbq.pop_front();
        checks++;
        if (ov !== e.m || od !== e.d) begin
            errors++;
            $display("FAIL uni_out: ov=%h od=%h want %h %h",
                     ov, od, e.m, e.d);
        end
        tick();
        checks++;
        if (ov !== 8'h00) begin
            errors++;
            $display("FAIL uni_clear: ov=%h want 00", ov);
        end
    endtask

    task automatic test_backpressure();
        valid = 1; data = 8'h11; sel = 5; ready = 8'hDF;
        sbq.push_back('{m: 8'h20, d: 8'h11});
        tick();
        valid = 0; data = 8'hEE; sel = 1; bcast = 1;
        e = sbq.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ov !== e.m || od !== e.d || rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%h od=%h rdy=%b want %h %h 0",
                         i, ov, od, rdy, e.m, e.d);
            end
            tick();
        end
        bcast = 0;
        ready = 8'hFF;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rdy=%b want 1", rdy);
        end
        tick();
        checks++;
        if (ov !== 8'h00) begin
            errors++;
            $display("FAIL bp_done: ov=%h want 00", ov);
        end
    endtask

    task automatic test_broadcast();
        valid = 1; data = 8'h3C; bcast = 1; sel = 2; ready = 8'h00;
        sbq.push_back('{m: 8'hFF, d: 8'h3C});
        tick();
        valid = 0; bcast = 0;
        e = sbq.pop_front();
        checks++;
        if (ov !== e.m || od !== e.d) begin
            errors++;
            $display("FAIL bc_load: ov=%h od=%h want %h %h",
                     ov, od, e.m, e.d);
        end
        ready = 8'h0F;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL bc_rdy1: rdy=%b want 0", rdy);
        end
        tick();
        checks++;
        if (ov !== 8'hF0 || od !== 8'h3C) begin
            errors++;
            $display("FAIL bc_part: ov=%h od=%h want f0 3c", ov, od);
        end
        ready = 8'hF0;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL bc_rdy2: rdy=%b want 1", rdy);
        end
        tick();
        checks++;
        if (ov !== 8'h00) begin
            errors++;
            $display("FAIL bc_done: ov=%h want 00", ov);
        end
    endtask

    task automatic test_back_to_back();
        ready = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            valid = 1;
            sel = 3'(i % 8);
            data = 8'(8'h40 + i);
            #1;
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_stall%0d: rdy=%b want 1", i, rdy);
            end
            sbq.push_back('{m: 8'(8'h01 << (i % 8)), d: 8'(8'h40 + i)});
            tick();
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL b2b_empty%0d: queue empty", i);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (ov !== e.m || od !== e.d) begin
                    errors++;
                    $display("FAIL b2b_word%0d: ov=%h od=%h want %h %h",
                             i, ov, od, e.m, e.d);
                end
            end
        end
        valid = 0;
        data = 8'h99;
        sel = 6;
        tick();
        checks++;
        if (ov !== 8'h00 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: ov=%h q=%0d want 00 0", ov, sbq.size());
        end
    endtask

    task automatic test_out_of_range();
        v6 = 1; sel6 = 5; d6 = 8'h5A; r6 = '0;
        tick();
        v6 = 0;
        checks++;
        if (ov6 !== 6'h20 || od6 !== 8'h5A || oe6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_edge: ov=%h od=%h oe=%b want 20 5a 0",
                     ov6, od6, oe6);
        end
        r6 = '1;
        tick();
        v6 = 1; sel6 = 7; d6 = 8'hC3;
        tick();
        v6 = 0;
        checks++;
        if (ov6 !== 6'h00 || oe6 !== 1'b1 || dc6 !== 8'd1) begin
            errors++;
            $display("FAIL oor_drop: ov=%h oe=%b dc=%0d want 00 1 1",
                     ov6, oe6, dc6);
        end
        tick();
        checks++;
        if (oe6 !== 1'b0 || dc6 !== 8'd1) begin
            errors++;
            $display("FAIL oor_pulse: oe=%b dc=%0d want 0 1", oe6, dc6);
        end
        v6 = 1; sel6 = 6;
        tick();
        v6 = 0;
        checks++;
        if (oe6 !== 1'b1 || dc6 !== 8'd2 || ov6 !== 6'h00) begin
            errors++;
            $display("FAIL oor_six: oe=%b dc=%0d ov=%h want 1 2 00",
                     oe6, dc6, ov6);
        end
        v6 = 1; sel6 = 7;
        for (int i = 0; i < 300; i++) tick();
        v6 = 0;
        checks++;
        if (dc6 !== 8'd255) begin
            errors++;
            $display("FAIL oor_sat: dc=%0d want 255", dc6);
        end
        tick();
        checks++;
        if (oe6 !== 1'b0 || dc6 !== 8'd255) begin
            errors++;
            $display("FAIL oor_hold: oe=%b dc=%0d want 0 255", oe6, dc6);
        end
    endtask

    task automatic test_reset_mid_hold();
        valid = 1; data = 8'h77; sel = 2; ready = 8'h00;
        tick();
        valid = 0;
        checks++;
        if (ov !== 8'h04 || od !== 8'h77) begin
            errors++;
            $display("FAIL rst_hold: ov=%h od=%h want 04 77", ov, od);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov !== 8'h00 || od !== 8'h00 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: ov=%h od=%h rdy=%b want 00 00 1",
                     ov, od, rdy);
        end
        checks++;
        if (dc6 !== 8'd0) begin
            errors++;
            $display("FAIL rst_cnt: dc=%0d want 0", dc6);
        end
        #2;
        rst_n = 1'b1;
        ready = 8'hFF;
        tick();
        valid = 1; data = 8'h81; sel = 7;
        tick();
        valid = 0;
        checks++;
        if (ov !== 8'h80 || od !== 8'h81) begin
            errors++;
            $display("FAIL rst_resume: ov=%h od=%h want 80 81", ov, od);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
